div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq_pkg.sv | 15 +
 rtl/div_seq_ctrl.sv | 65 ++++++
 rtl/div_seq.sv | 84 ++++++++
 tb/tb_div_seq.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential repeated-subtraction divider.
package div_seq_pkg;

  // Operand/result width used when the instantiating scope does not override it.
  localparam int DEFAULT_WIDTH = 16;

  // Controller states: wait for a request, capture operands, subtract, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/div_seq_ctrl.sv
// Control FSM for div_seq: sequences LOAD, the subtract loop and result hand-off.
module div_seq_ctrl
  import div_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic b_zero,
  input  logic r_ge_b,
  output logic ld,
  output logic sub,
  output logic busy,
  output logic done
);

  state_e state_q;
  state_e state_d;

  // State register; reset drops straight back to IDLE, aborting any division.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore/strobe decode.
  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    sub     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        ld      = 1'b1;
        busy    = 1'b1;
        // A zero divisor skips the loop entirely; R >= 0 would never terminate.
        state_d = b_zero ? DONE : SUB;
      end
      SUB: begin
        busy = 1'b1;
        if (r_ge_b) begin
          sub = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // Start must drop before another operation can begin, so a held
        // request cannot retrigger.
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned divider: one compare/subtract per cycle, result held until next LOAD.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             dbz_q, dbz_d;

  logic             ld;
  logic             sub;
  logic             b_zero;
  logic             r_ge_b;
  logic [WIDTH-1:0] r_minus_b;

  // b_zero is only consumed in LOAD, where the divisor has not been captured yet.
  assign b_zero    = (divisor == '0);
  assign r_ge_b    = (r_q >= b_q);
  // Only applied when r_ge_b, so it never underflows.
  assign r_minus_b = r_q - b_q;

  div_seq_ctrl u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .b_zero (b_zero),
    .r_ge_b (r_ge_b),
    .ld     (ld),
    .sub    (sub),
    .busy   (busy),
    .done   (done)
  );

  // Datapath next-state: capture on LOAD, step on SUB, otherwise hold the last result.
  always_comb begin
    r_d   = r_q;
    q_d   = q_q;
    b_d   = b_q;
    dbz_d = dbz_q;
    if (ld) begin
      r_d   = dividend;
      b_d   = divisor;
      q_d   = b_zero ? '1 : '0;
      dbz_d = b_zero;
    end else if (sub) begin
      r_d = r_minus_b;
      q_d = q_q + WIDTH'(1);
    end
  end

  // Datapath registers; reset clears everything so an aborted run leaves no partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      q_q   <= '0;
      b_q   <= '0;
      dbz_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      q_q   <= q_d;
      b_q   <= b_d;
      dbz_q <= dbz_d;
    end
  end

  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: a 16-bit and an 8-bit instance, scoreboard of expected results.
module tb_div_seq;

  typedef struct {
    bit          w8;
    int unsigned exp_q;
    int unsigned exp_r;
    bit          exp_dbz;
    int          exp_lat;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        start16 = 1'b0;
  logic [15:0] dvd16 = '0, dvs16 = '0;
  logic [15:0] q16, r16;
  logic        busy16, done16, dbz16;

  logic        start8 = 1'b0;
  logic [7:0]  dvd8 = '0, dvs8 = '0;
  logic [7:0]  q8, r8;
  logic        busy8, done8, dbz8;

  int tests_run = 0;
  int fails = 0;
  sb_item_t sb[$];

  always #5 clk = ~clk;

  div_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .dividend(dvd16), .divisor(dvs16),
    .quotient(q16), .remainder(r16), .busy(busy16), .done(done16), .div_by_zero(dbz16)
  );

  div_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .quotient(q8), .remainder(r8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference result: plain integer division, all-ones quotient for a zero divisor.
  function automatic sb_item_t model(input bit w8, input int unsigned a, input int unsigned b);
    sb_item_t it;
    it.w8 = w8;
    if (b == 0) begin
      it.exp_q   = w8 ? 32'hFF : 32'hFFFF;
      it.exp_r   = a;
      it.exp_dbz = 1'b1;
      it.exp_lat = 2;
    end else begin
      it.exp_q   = a / b;
      it.exp_r   = a % b;
      it.exp_dbz = 1'b0;
      it.exp_lat = int'(a / b) + 3;
    end
    return it;
  endfunction

  task automatic drive(input bit w8, input int unsigned a, input int unsigned b, input logic s);
    if (w8) begin dvd8 = a[7:0]; dvs8 = b[7:0]; start8 = s; end
    else begin dvd16 = a[15:0]; dvs16 = b[15:0]; start16 = s; end
  endtask

  // Launch one division, count edges from the sampling edge until done, then score it.
  // chg_at > 0 overwrites the dividend with 1 after that many edges.
  task automatic run_op(input string tag, input bit w8, input int unsigned a,
                        input int unsigned b, input bit hold, input int chg_at);
    sb_item_t it;
    int n;
    bit timed_out;
    sb.push_back(model(w8, a, b));
    @(posedge clk); #1;
    drive(w8, a, b, 1'b1);
    n = 0;
    timed_out = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (n == 1 && !hold) begin
        if (w8) start8 = 1'b0; else start16 = 1'b0;
      end
      if (n == chg_at) begin
        if (w8) dvd8 = 8'd1; else dvd16 = 16'd1;
      end
      if (w8 ? done8 : done16) break;
      if (n > 70000) begin timed_out = 1'b1; break; end
    end
    it = sb.pop_front();
    check({tag, " timeout"}, 32'(timed_out), 32'd0);
    check({tag, " latency"}, n, it.exp_lat);
    check({tag, " quotient"}, it.w8 ? 32'(q8) : 32'(q16), it.exp_q);
    check({tag, " remainder"}, it.w8 ? 32'(r8) : 32'(r16), it.exp_r);
    check({tag, " div_by_zero"}, it.w8 ? 32'(dbz8) : 32'(dbz16), 32'(it.exp_dbz));
    check({tag, " busy"}, it.w8 ? 32'(busy8) : 32'(busy16), 32'd0);
  endtask

  initial begin
    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset quotient", 32'(q16), 32'd0);
    check("reset remainder", 32'(r16), 32'd0);
    check("reset busy", 32'(busy16), 32'd0);
    check("reset done", 32'(done16), 32'd0);
    check("reset div_by_zero", 32'(dbz16), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op("100/7", 1'b0, 100, 7, 1'b0, 0);
    run_op("5/9", 1'b0, 5, 9, 1'b0, 0);
    run_op("0/3", 1'b0, 0, 3, 1'b0, 0);
    run_op("12/0", 1'b0, 12, 0, 1'b0, 0);
    run_op("12/4", 1'b0, 12, 4, 1'b0, 0);

    // Result must persist while idling.
    repeat (3) @(posedge clk);
    #1;
    check("idle keeps quotient", 32'(q16), 32'd3);
    check("idle done low", 32'(done16), 32'd0);

    run_op("60/6 operand change", 1'b0, 60, 6, 1'b0, 4);
    run_op("65535/65535", 1'b0, 65535, 65535, 1'b0, 0);

    // Worst case at WIDTH=8, with start held high through DONE.
    run_op("w8 255/1", 1'b1, 255, 1, 1'b1, 0);
    repeat (5) @(posedge clk);
    #1;
    check("w8 held start stays done", 32'(done8), 32'd1);
    check("w8 held start not busy", 32'(busy8), 32'd0);
    check("w8 held quotient", 32'(q8), 32'd255);
    start8 = 1'b0;
    @(posedge clk); #1;
    check("w8 start low leaves done", 32'(done8), 32'd0);
    run_op("w8 200/7", 1'b1, 200, 7, 1'b0, 0);

    // Reset in the middle of a subtract loop aborts with nothing retained.
    @(posedge clk); #1;
    drive(1'b0, 200, 3, 1'b1);
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid-run busy", 32'(busy16), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort quotient", 32'(q16), 32'd0);
    check("abort remainder", 32'(r16), 32'd0);
    check("abort busy", 32'(busy16), 32'd0);
    check("abort done", 32'(done16), 32'd0);
    check("abort div_by_zero", 32'(dbz16), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_op("9/3 after reset", 1'b0, 9, 3, 1'b0, 0);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
